fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 132 +++++++++++++
 tb/tb_fifo_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: drains a 4-deep first-word-fall-through FIFO into a registered output stage.
// Latency: a word at the FIFO head while the output stage is empty appears on data_out one cycle later.
// Backpressure: data_out_ready=0 holds data_out/data_out_valid stable and stops popping the FIFO.
//
// Ports:
//   clk, rst         single clock; asynchronous active-high reset
//   fifo_empty       FIFO holds no words
//   fifo_full        FIFO holds 4 words (empty and full together is a protocol error)
//   fifo_data        head-of-FIFO word, valid whenever fifo_empty=0
//   pop_fifo         removes the head word at the rising edge where it is high
//   data_out         registered word presented downstream
//   data_out_valid   data_out holds an unconsumed word
//   data_out_ready   downstream accepts data_out this cycle
//   err              sticky protocol-error flag, cleared only by reset
//   words_read       completed downstream transfers, wraps at 256
//
// Build option: define FIFO_READER_CNT_EN to enable the words_read counter;
// without it words_read is tied to zero.

module fifo_reader #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             pop_fifo,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic             err,
    output logic [7:0]       words_read
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // output register empty
        ST_HOLD = 2'd1,   // output register holds an unconsumed word
        ST_ERR  = 2'd2    // protocol error seen; only reset leaves
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop_c;
    logic             proto_err;

    // The FIFO can never be empty and full at once; seeing both means the
    // upstream flags are corrupt, so we stop trusting them for good.
    assign proto_err = fifo_empty & fifo_full;

    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A ready downstream frees the register this cycle, so it can
                // be refilled on the same edge for one word per cycle.
                if (data_out_ready) begin
                    if (!fifo_empty) begin
                        pop_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        if (proto_err) begin
            state_d = ST_ERR;
        end

        if (pop_c) begin
            data_d = fifo_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Gate with rst so no pop is requested while reset is held, even though
    // the state register already reads IDLE.
    assign pop_fifo       = pop_c & ~rst;
    assign data_out       = data_q;
    assign data_out_valid = (state_q == ST_HOLD);
    assign err            = (state_q == ST_ERR);

`ifdef FIFO_READER_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // A transfer is valid && ready; the 8-bit add wraps 255 -> 0 naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (data_out_valid && data_out_ready) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign words_read = cnt_q;
`else
    assign words_read = 8'h00;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO environment plus an output-slot
// reference model; every cycle compares pop, valid, data, err and words_read.

module tb_fifo_reader;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic         fifo_full;
    logic [W-1:0] fifo_data;
    logic         pop_fifo;
    logic [W-1:0] data_out;
    logic         data_out_valid;
    logic         data_out_ready;
    logic         err;
    logic [7:0]   words_read;

    fifo_reader #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_data      (fifo_data),
        .pop_fifo       (pop_fifo),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .err            (err),
        .words_read     (words_read)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment FIFO contents (front = head word).
    logic [W-1:0] fq[$];

    // Reference model: the output slot as "occupied or not" plus its word,
    // a sticky error bit and a transfer count.
    bit           m_hold;
    bit           m_err;
    logic [W-1:0] m_word;
    int           m_xfers;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_count();
`ifdef FIFO_READER_CNT_EN
        return m_xfers[7:0];
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        m_hold  = 1'b0;
        m_err   = 1'b0;
        m_word  = '0;
        m_xfers = 0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle. Entered at posedge+1, returns at the next posedge+1.
    // inj forces empty and full together for this cycle.
    task automatic step(input bit rdy, input bit inj);
        bit e_pop;
        bit emp;
        bit xfer;
        data_out_ready = rdy;
        if (inj) begin
            fifo_empty = 1'b1;
            fifo_full  = 1'b1;
            fifo_data  = rnd_word();
        end else begin
            fifo_empty = (fq.size() == 0);
            fifo_full  = (fq.size() == 4);
            fifo_data  = (fq.size() != 0) ? fq[0] : rnd_word();
        end
        emp = fifo_empty;
        @(negedge clk);
        e_pop = !m_err && !emp && (!m_hold || rdy);
        check("pop_fifo", W'(pop_fifo), W'(e_pop));
        check("data_out_valid", W'(data_out_valid), W'(m_hold));
        check("data_out", data_out, m_word);
        check("err", W'(err), W'(m_err));
        check("words_read", W'(words_read), W'(exp_count()));
        xfer = m_hold && rdy;
        if (xfer) m_xfers++;
        if (inj) begin
            m_err  = 1'b1;
            m_hold = 1'b0;
        end else if (!m_err) begin
            if (e_pop) begin
                m_word = fq.pop_front();
                m_hold = 1'b1;
            end else if (xfer) begin
                m_hold = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and check outputs clear before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_data_out", data_out, '0);
        check("rst_valid", W'(data_out_valid), '0);
        check("rst_err", W'(err), '0);
        check("rst_pop", W'(pop_fifo), '0);
        check("rst_words_read", W'(words_read), '0);
        model_reset();
        @(posedge clk);
        #1;
        fifo_empty = 1'b0;
        fifo_full  = 1'b0;
        @(negedge clk);
        check("rst_pop_held", W'(pop_fifo), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        int pushed;
        rst            = 1'b1;
        fifo_empty     = 1'b1;
        fifo_full      = 1'b0;
        fifo_data      = '0;
        data_out_ready = 1'b0;
        model_reset();
        #1;
        check("init_data_out", data_out, '0);
        check("init_valid", W'(data_out_valid), '0);
        check("init_err", W'(err), '0);
        check("init_pop", W'(pop_fifo), '0);
        check("init_words_read", W'(words_read), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with an empty FIFO.
        for (int i = 0; i < 5; i++) step($urandom_range(0, 1), 1'b0);

        // Four-word burst with downstream always ready.
        fq.push_back(64'hA1); fq.push_back(64'hB2);
        fq.push_back(64'hC3); fq.push_back(64'hD4);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check("burst_words_read", W'(words_read), W'(exp_count()));
`ifdef FIFO_READER_CNT_EN
        check("burst_count_4", W'(words_read), W'(8'd4));
`else
        check("burst_count_0", W'(words_read), W'(8'd0));
`endif

        // Backpressure: 0x55 held while FIFO is not empty.
        fq.push_back(64'h55); fq.push_back(64'h66);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("bp_next_word", data_out, 64'h66);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 4 && $urandom_range(0, 2) != 0) fq.push_back(rnd_word());
            step($urandom_range(0, 3) != 0, 1'b0);
        end

        // Protocol error while holding a word.
        fq.delete();
        fq.push_back(rnd_word());
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("err_set", W'(err), '1 >> (W - 1));
        for (int i = 0; i < 6; i++) begin
            if (fq.size() < 4) fq.push_back(rnd_word());
            step($urandom_range(0, 1), 1'b0);
        end

        // Reset mid-hold with 0x77 in the output register.
        fq.delete();
        do_reset();
        fq.push_back(64'h77);
        fq.push_back(64'h88);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pre_rst_0x77", data_out, 64'h77);
        do_reset();
        fq.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // 257 transfers: the counter wraps once and ends at 1.
        do_reset();
        pushed = 0;
        guard  = 0;
        while ((pushed < 257 || fq.size() != 0 || m_hold) && guard < 2000) begin
            if (pushed < 257 && fq.size() < 4 && $urandom_range(0, 4) != 0) begin
                fq.push_back(rnd_word());
                pushed++;
            end
            step($urandom_range(0, 4) != 0, 1'b0);
            guard++;
        end
        check("wrap_budget", W'(guard < 2000), W'(1));
        check("wrap_xfers", W'(m_xfers), W'(257));
`ifdef FIFO_READER_CNT_EN
        check("wrap_count_1", W'(words_read), W'(8'd1));
`else
        check("wrap_count_0", W'(words_read), W'(8'd0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
